// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants: timer FSM states, stop-bit count
// and a counter-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } rx_timer_state_t;

    localparam int STOP_BITS = 1;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter that runs 1..rollover_val and wraps back to 1. The registered
// rollover_flag pulses for one cycle on each wrap.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count         <= WIDTH'(1);
                rollover_flag <= 1'b1;
            end else begin
                count         <= count + WIDTH'(1);
                rollover_flag <= 1'b0;
            end
        end else begin
            rollover_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_timer.sv
// UART receiver bit timer: emits a shift_strobe at each data/stop sample
// point while enable_timer is held, then a single packet_done pulse.
module rx_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIRST_SAMPLE = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_timer,
    output logic            shift_strobe,
    output logic            packet_done,
    output logic [3:0]      bit_index,
    output logic            busy,
    output rx_timer_state_t dbg_state
);

    localparam int MAX_PERIOD = (CLKS_PER_BIT > FIRST_SAMPLE) ? CLKS_PER_BIT : FIRST_SAMPLE;
    localparam int CNT_W      = cnt_width(MAX_PERIOD);

    localparam logic [CNT_W-1:0] FIRST_TGT  = CNT_W'(FIRST_SAMPLE);
    localparam logic [CNT_W-1:0] PERIOD_TGT = CNT_W'(CLKS_PER_BIT);
    localparam logic [3:0]       LAST_BIT   = 4'(DATA_BITS + STOP_BITS - 1);

    rx_timer_state_t  state, next_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_target;
    logic [3:0]       bit_cnt;
    logic             clk_clear, clk_en;
    logic             bit_clear, bit_en;
    logic             strobe_flag, stop_flag;
    logic             sample_hit;

    // Abort wins over a coincident sample point because enable_timer gates the hit.
    assign clk_target = (bit_cnt == 4'd0) ? FIRST_TGT : PERIOD_TGT;
    assign sample_hit = (state == COUNT) && enable_timer && (clk_cnt == clk_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (enable_timer) next_state = COUNT;
            COUNT: begin
                if (!enable_timer) begin
                    next_state = IDLE;
                end else if (sample_hit && (bit_cnt == LAST_BIT)) begin
                    next_state = DONE;
                end
            end
            DONE:  if (!enable_timer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        clk_clear = 1'b1;
        clk_en    = 1'b0;
        bit_clear = 1'b0;
        bit_en    = 1'b0;
        case (state)
            IDLE: begin
                bit_clear = 1'b1;
                if (enable_timer) begin
                    clk_clear = 1'b0;
                    clk_en    = 1'b1;
                end
            end
            COUNT: begin
                if (enable_timer) begin
                    clk_clear = 1'b0;
                    clk_en    = 1'b1;
                    bit_en    = sample_hit;
                end else begin
                    bit_clear = 1'b1;
                end
            end
            default: begin
                bit_clear = 1'b1;
            end
        endcase
    end

    flex_counter #(.WIDTH(CNT_W)) u_clk_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (clk_clear),
        .count_enable (clk_en),
        .rollover_val (clk_target),
        .count        (clk_cnt),
        .rollover_flag(strobe_flag)
    );

    // The bit counter wraps on the stop bit; its flag marks frame completion.
    flex_counter #(.WIDTH(4)) u_bit_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (bit_clear),
        .count_enable (bit_en),
        .rollover_val (LAST_BIT),
        .count        (bit_cnt),
        .rollover_flag(stop_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            packet_done <= 1'b0;
            busy        <= 1'b0;
            bit_index   <= 4'd0;
        end else begin
            packet_done <= stop_flag;
            busy        <= (next_state != IDLE);
            if (sample_hit) begin
                bit_index <= bit_cnt;
            end
        end
    end

    assign shift_strobe = strobe_flag;
    assign dbg_state    = state;

endmodule

// File: tb/tb_rx_timer.sv
// Directed bench for rx_timer: per-frame vector tables of expected outputs at
// given offsets from T0, with off-table cycles required to be pulse-free.
module tb_rx_timer;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, en0, en1;
    logic            s0, d0, b0, s1, d1, b1;
    logic [3:0]      i0, i1;
    rx_timer_state_t st0, st1;

    rx_timer u_def (
        .clk(clk), .rst(rst), .enable_timer(en0), .shift_strobe(s0),
        .packet_done(d0), .bit_index(i0), .busy(b0), .dbg_state(st0)
    );

    rx_timer #(.CLKS_PER_BIT(16), .FIRST_SAMPLE(24), .DATA_BITS(7)) u_alt (
        .clk(clk), .rst(rst), .enable_timer(en1), .shift_strobe(s1),
        .packet_done(d1), .bit_index(i1), .busy(b1), .dbg_state(st1)
    );

    int              sel;
    logic            m_strobe, m_done, m_busy;
    logic [3:0]      m_idx;
    rx_timer_state_t m_state;
    assign m_strobe = (sel != 0) ? s1 : s0;
    assign m_done   = (sel != 0) ? d1 : d0;
    assign m_busy   = (sel != 0) ? b1 : b0;
    assign m_idx    = (sel != 0) ? i1 : i0;
    assign m_state  = (sel != 0) ? st1 : st0;

    typedef struct {
        int         off;
        logic       strobe;
        logic [3:0] idx;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int off, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s off=%0d actual=%0h required=%0h", name, off, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic v);
        if (sel != 0) en1 = v;
        else          en0 = v;
    endtask

    task automatic add(input int off, input logic s, input int idx, input logic d,
                       input logic b);
        vecs.push_back('{off, s, 4'(idx), d, b});
    endtask

    // Start a frame (edge T0), then enable is sampled low from offset d on and
    // reset is pulsed at offset r (-1 for none).
    task automatic run_frame(input int d, input int r, input int last_off);
        int ti;
        set_en(1'b1);
        tick();
        check("t0_strobe", 0, 32'(m_strobe), 32'd0);
        for (int n = 1; n <= last_off; n++) begin
            set_en(n < d);
            rst = (n == r);
            tick();
            rst = 1'b0;
            ti = -1;
            foreach (vecs[i]) if (vecs[i].off == n) ti = i;
            if (ti >= 0) begin
                check("vec_strobe", n, 32'(m_strobe), 32'(vecs[ti].strobe));
                check("vec_index",  n, 32'(m_idx),    32'(vecs[ti].idx));
                check("vec_done",   n, 32'(m_done),   32'(vecs[ti].done));
                check("vec_busy",   n, 32'(m_busy),   32'(vecs[ti].busy));
            end else begin
                check("no_strobe", n, 32'(m_strobe), 32'd0);
                check("no_done",   n, 32'(m_done),   32'd0);
                check("busy",      n, 32'(m_busy),   32'((n < d) && (n != r)));
            end
        end
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            sel = k;
            #0;
            check("rst_strobe", -1, 32'(m_strobe), 32'd0);
            check("rst_done",   -1, 32'(m_done),   32'd0);
            check("rst_busy",   -1, 32'(m_busy),   32'd0);
            check("rst_index",  -1, 32'(m_idx),    32'd0);
            check("rst_state",  -1, 32'(m_state),  32'(IDLE));
        end
        sel = 0;
        rst = 1'b0;
        tick();

        // Default frame, enable held 20 cycles past packet_done, then two back-to-back.
        vecs.delete();
        for (int k = 0; k <= 8; k++) add(10 + 10 * k, 1'b1, k, 1'b0, 1'b1);
        add(91, 1'b0, 8, 1'b1, 1'b1);
        add(95, 1'b0, 8, 1'b0, 1'b1);
        add(111, 1'b0, 8, 1'b0, 1'b1);
        add(112, 1'b0, 8, 1'b0, 1'b0);
        run_frame(112, -1, 112);
        check("idle_after_drop", 112, 32'(m_state), 32'(IDLE));
        run_frame(112, -1, 112);
        tick();
        tick();

        // Abort exactly at the sample point T0+50, then a fresh frame.
        vecs.delete();
        for (int k = 0; k <= 3; k++) add(10 + 10 * k, 1'b1, k, 1'b0, 1'b1);
        add(50, 1'b0, 3, 1'b0, 1'b0);
        add(51, 1'b0, 3, 1'b0, 1'b0);
        run_frame(50, -1, 55);
        check("abort_state", 55, 32'(m_state), 32'(IDLE));
        vecs.delete();
        add(9, 1'b0, 3, 1'b0, 1'b1);
        add(10, 1'b1, 0, 1'b0, 1'b1);
        add(20, 1'b1, 1, 1'b0, 1'b1);
        run_frame(1000, -1, 25);
        set_en(1'b0);
        tick();
        tick();

        // Reset at T0+45 with enable held high: restart with a new T0 at 46.
        vecs.delete();
        for (int k = 0; k <= 3; k++) add(10 + 10 * k, 1'b1, k, 1'b0, 1'b1);
        add(45, 1'b0, 0, 1'b0, 1'b0);
        add(46, 1'b0, 0, 1'b0, 1'b1);
        add(50, 1'b0, 0, 1'b0, 1'b1);
        add(56, 1'b1, 0, 1'b0, 1'b1);
        run_frame(1000, 45, 60);
        set_en(1'b0);
        tick();
        tick();

        // Non-default timing: 16 clocks per bit, first sample at 24, 7 data bits.
        sel = 1;
        vecs.delete();
        for (int k = 0; k <= 7; k++) add(24 + 16 * k, 1'b1, k, 1'b0, 1'b1);
        add(137, 1'b0, 7, 1'b1, 1'b1);
        add(139, 1'b0, 7, 1'b0, 1'b1);
        add(140, 1'b0, 7, 1'b0, 1'b0);
        run_frame(140, -1, 141);
        check("alt_state", 141, 32'(m_state), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
